// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap/interrupt control unit: state encodings
// and the default width/timeout values.
package trap_ctrl_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_WAIT_JMP = 2'd2
  } trap_state_e;

endpackage : trap_ctrl_pkg

// File: rtl/trap_ctrl.sv
// Pipeline-side trap/interrupt controller. Picks a safe retire boundary,
// drains the pipeline for interrupts, raises one-cycle requests towards the
// CSR file and turns its jmp_en/jmp_pc answer into a fetch redirect + flush.
// Every output is driven straight from a register.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            retire_valid,
  input  logic [XLEN-1:0] retire_pc,
  input  logic [XLEN-1:0] retire_pc_next,
  input  logic            retire_mret,
  input  logic            retire_exc,
  input  logic [XLEN-1:0] retire_exc_code,
  input  logic [XLEN-1:0] retire_exc_val,
  input  logic            pipe_empty,
  input  logic            int_en,
  input  logic            jmp_en,
  input  logic [XLEN-1:0] jmp_pc,
  output logic            int_jmp_ready,
  output logic            exception_en,
  output logic            mret_en,
  output logic [XLEN-1:0] exp_pc,
  output logic [XLEN-1:0] exp_pc_next,
  output logic [XLEN-1:0] exp_val,
  output logic [XLEN-1:0] exception_code,
  output logic            stall_fetch,
  output logic            flush,
  output logic            redirect_en,
  output logic [XLEN-1:0] redirect_pc,
  output logic            trap_err
);

  // Wide enough to hold TIMEOUT itself.
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  trap_state_e     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] last_pc_next_q, last_pc_next_d;

  logic            int_jmp_ready_q, int_jmp_ready_d;
  logic            exception_en_q, exception_en_d;
  logic            mret_en_q, mret_en_d;
  logic [XLEN-1:0] exp_pc_q, exp_pc_d;
  logic [XLEN-1:0] exp_pc_next_q, exp_pc_next_d;
  logic [XLEN-1:0] exp_val_q, exp_val_d;
  logic [XLEN-1:0] exception_code_q, exception_code_d;
  logic            stall_fetch_q, stall_fetch_d;
  logic            flush_q, flush_d;
  logic            redirect_en_q, redirect_en_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            trap_err_q, trap_err_d;

  logic retire_exc_ev;
  logic retire_mret_ev;

  assign retire_exc_ev  = retire_valid & retire_exc;
  assign retire_mret_ev = retire_valid & retire_mret & ~retire_exc;

  // Next-state and registered-output decode; pulses default low, payloads hold.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    last_pc_next_d   = retire_valid ? retire_pc_next : last_pc_next_q;
    int_jmp_ready_d  = 1'b0;
    exception_en_d   = 1'b0;
    mret_en_d        = 1'b0;
    flush_d          = 1'b0;
    redirect_en_d    = 1'b0;
    exp_pc_d         = exp_pc_q;
    exp_pc_next_d    = exp_pc_next_q;
    exp_val_d        = exp_val_q;
    exception_code_d = exception_code_q;
    redirect_pc_d    = redirect_pc_q;
    trap_err_d       = trap_err_q;

    unique case (state_q)
      ST_IDLE, ST_DRAIN: begin
        // An unsolicited redirect is still honoured; it does not disturb
        // the boundary decision below.
        if (jmp_en) begin
          redirect_en_d = 1'b1;
          redirect_pc_d = jmp_pc;
          flush_d       = 1'b1;
        end

        if (retire_exc_ev) begin
          exception_en_d   = 1'b1;
          exp_pc_d         = retire_pc;
          exp_val_d        = retire_exc_val;
          exception_code_d = retire_exc_code;
          cnt_d            = '0;
          state_d          = ST_WAIT_JMP;
        end else if (retire_mret_ev) begin
          mret_en_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_WAIT_JMP;
        end else if (state_q == ST_IDLE) begin
          if (int_en) state_d = ST_DRAIN;
        end else if (!int_en) begin
          // Interrupt withdrawn while draining.
          state_d = ST_IDLE;
        end else if (pipe_empty) begin
          int_jmp_ready_d = 1'b1;
          exp_pc_next_d   = retire_valid ? retire_pc_next : last_pc_next_q;
          cnt_d           = '0;
          state_d         = ST_WAIT_JMP;
        end
      end

      ST_WAIT_JMP: begin
        // Retire activity is ignored here: fetch is stalled.
        if (jmp_en) begin
          redirect_en_d = 1'b1;
          redirect_pc_d = jmp_pc;
          flush_d       = 1'b1;
          state_d       = ST_IDLE;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          trap_err_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Fetch is held in every state except IDLE.
    stall_fetch_d = (state_d != ST_IDLE);
  end

  // State, counter and output registers; async active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      last_pc_next_q   <= '0;
      int_jmp_ready_q  <= 1'b0;
      exception_en_q   <= 1'b0;
      mret_en_q        <= 1'b0;
      exp_pc_q         <= '0;
      exp_pc_next_q    <= '0;
      exp_val_q        <= '0;
      exception_code_q <= '0;
      stall_fetch_q    <= 1'b0;
      flush_q          <= 1'b0;
      redirect_en_q    <= 1'b0;
      redirect_pc_q    <= '0;
      trap_err_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      last_pc_next_q   <= last_pc_next_d;
      int_jmp_ready_q  <= int_jmp_ready_d;
      exception_en_q   <= exception_en_d;
      mret_en_q        <= mret_en_d;
      exp_pc_q         <= exp_pc_d;
      exp_pc_next_q    <= exp_pc_next_d;
      exp_val_q        <= exp_val_d;
      exception_code_q <= exception_code_d;
      stall_fetch_q    <= stall_fetch_d;
      flush_q          <= flush_d;
      redirect_en_q    <= redirect_en_d;
      redirect_pc_q    <= redirect_pc_d;
      trap_err_q       <= trap_err_d;
    end
  end

  assign int_jmp_ready  = int_jmp_ready_q;
  assign exception_en   = exception_en_q;
  assign mret_en        = mret_en_q;
  assign exp_pc         = exp_pc_q;
  assign exp_pc_next    = exp_pc_next_q;
  assign exp_val        = exp_val_q;
  assign exception_code = exception_code_q;
  assign stall_fetch    = stall_fetch_q;
  assign flush          = flush_q;
  assign redirect_en    = redirect_en_q;
  assign redirect_pc    = redirect_pc_q;
  assign trap_err       = trap_err_q;

endmodule : trap_ctrl
